// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: instruction-decode control stage.
//
// Decodes the opcode/funct fields of an offered instruction into a 15-bit
// control word and a destination register, and registers the result behind a
// valid/ready handshake. A load-use interlock holds back an instruction that
// reads the destination of the load currently in the output register, and
// inserts bubbles while it waits.
//
// Parameters
//   REG_AW    register-address width (opcode/funct stay 6 bits)
//   HAZ_EN    1 = load-use interlock active, 0 = interlock removed
//   STALL_CYC extra stall cycles per load-use hazard, 1..4
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_opcode, i_funct         instruction opcode / function fields
//   i_rs, i_rt, i_rd          instruction register fields
//   i_valid / o_ready         upstream handshake
//   o_valid / i_ready         downstream handshake
//   i_flush                   kill held and offered instruction
//   o_ctrl                    registered control word
//   o_opcode, o_funct         registered instruction fields
//   o_rs, o_rt, o_dst         registered source / destination registers
//   o_dst_wr                  registered "destination is written"
//   o_stall                   combinational: interlock is holding input back
module id_ctrl_stage #(
  parameter int REG_AW    = 5,
  parameter bit HAZ_EN    = 1'b1,
  parameter int STALL_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [5:0]        i_opcode,
  input  logic [5:0]        i_funct,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic              i_flush,
  output logic [14:0]       o_ctrl,
  output logic [5:0]        o_opcode,
  output logic [5:0]        o_funct,
  output logic [REG_AW-1:0] o_rs,
  output logic [REG_AW-1:0] o_rt,
  output logic [REG_AW-1:0] o_dst,
  output logic              o_dst_wr,
  output logic              o_stall
);

  // Control word bit positions
  localparam int C_SWAP_RS_SH  = 0;
  localparam int C_SWAP_RS_RT  = 1;
  localparam int C_SWAP_RT_IMM = 2;
  localparam int C_SIGNED_EXT  = 3;
  localparam int C_MEM_RD      = 4;
  localparam int C_RG_WRITE    = 5;
  localparam int C_BYTE_RD     = 6;
  localparam int C_SIGNED_RD   = 7;
  localparam int C_2BYTE_RD    = 8;
  localparam int C_4BYTE_RD    = 9;
  localparam int C_MEM_WR      = 10;
  localparam int C_BYTE_WR     = 11;
  localparam int C_2BYTE_WR    = 12;
  localparam int C_4BYTE_WR    = 13;
  localparam int C_RG_WR_IMM   = 14;

  // Out-of-range STALL_CYC values are clamped into the legal 1..4 range so the
  // 2-bit counter can always hold STALL_CYC-1.
  localparam int STALL_EFF = (STALL_CYC < 1) ? 1 : ((STALL_CYC > 4) ? 4 : STALL_CYC);
  localparam logic [1:0] CNT_LOAD = 2'(STALL_EFF - 1);

  typedef enum logic {RUN, STALL} state_t;

  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op[5:3] == 3'b001);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    logic r;
    case (op)
      6'h20, 6'h21, 6'h22, 6'h24, 6'h25: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    logic r;
    case (op)
      6'h28, 6'h29, 6'h2B: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [14:0] decode_ctrl(input logic [5:0] op, input logic [5:0] fn);
    logic [14:0] c;
    c = '0;
    if (op == 6'h00) begin
      c[C_RG_WRITE] = 1'b1;
      case (fn)
        6'd0, 6'd2, 6'd3: begin
          c[C_SWAP_RS_SH] = 1'b1;
          c[C_SWAP_RS_RT] = 1'b1;
        end
        6'd4, 6'd6, 6'd7: c[C_SWAP_RS_RT] = 1'b1;
        default: ;
      endcase
    end else if (is_imm_alu(op)) begin
      c[C_SWAP_RT_IMM] = 1'b1;
      c[C_RG_WR_IMM]   = 1'b1;
      // Logical immediates (12/13/14) zero-extend
      c[C_SIGNED_EXT]  = !((op == 6'd12) || (op == 6'd13) || (op == 6'd14));
    end else if (is_load(op) || is_store(op)) begin
      c[C_SWAP_RT_IMM] = 1'b1;
      c[C_SIGNED_EXT]  = 1'b1;
      case (op)
        6'h20: begin c[C_MEM_RD] = 1'b1; c[C_BYTE_RD]  = 1'b1; c[C_SIGNED_RD] = 1'b1; end
        6'h21: begin c[C_MEM_RD] = 1'b1; c[C_2BYTE_RD] = 1'b1; c[C_SIGNED_RD] = 1'b1; end
        6'h22: begin c[C_MEM_RD] = 1'b1; c[C_4BYTE_RD] = 1'b1; c[C_SIGNED_RD] = 1'b1; end
        6'h24: begin c[C_MEM_RD] = 1'b1; c[C_BYTE_RD]  = 1'b1; end
        6'h25: begin c[C_MEM_RD] = 1'b1; c[C_2BYTE_RD] = 1'b1; end
        6'h28: begin c[C_MEM_WR] = 1'b1; c[C_BYTE_WR]  = 1'b1; end
        6'h29: begin c[C_MEM_WR] = 1'b1; c[C_2BYTE_WR] = 1'b1; end
        6'h2B: begin c[C_MEM_WR] = 1'b1; c[C_4BYTE_WR] = 1'b1; end
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  // Stage p0: combinational decode of the offered instruction
  logic [14:0]       ctrl_p0;
  logic [REG_AW-1:0] dst_p0;
  logic              dst_wr_p0;

  always_comb begin
    ctrl_p0 = decode_ctrl(i_opcode, i_funct);
    dst_p0  = '0;
    if (i_opcode == 6'h00) begin
      dst_p0 = i_rd;
    end else if (is_imm_alu(i_opcode) || is_load(i_opcode)) begin
      dst_p0 = i_rt;
    end
    // Writes to register 0 are discarded, so the write-enable bits drop too
    if (dst_p0 == '0) begin
      ctrl_p0[C_RG_WRITE]  = 1'b0;
      ctrl_p0[C_RG_WR_IMM] = 1'b0;
    end
    dst_wr_p0 = (ctrl_p0[C_RG_WRITE] | ctrl_p0[C_RG_WR_IMM] | ctrl_p0[C_MEM_RD])
              & (dst_p0 != '0);
  end

  // Stage p1: output register, load tracking and interlock
  logic              vld_p1;
  logic [14:0]       ctrl_p1;
  logic [5:0]        opcode_p1;
  logic [5:0]        funct_p1;
  logic [REG_AW-1:0] rs_p1;
  logic [REG_AW-1:0] rt_p1;
  logic [REG_AW-1:0] dst_p1;
  logic              dst_wr_p1;
  logic              ld_pend_p1;
  logic [REG_AW-1:0] ld_dst_p1;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;

  logic load_en;
  logic rt_used;
  logic hazard;
  logic xfer;

  assign load_en = !vld_p1 | i_ready;
  // rt is a source operand only for register-register ops and stores
  assign rt_used = (i_opcode == 6'h00) | is_store(i_opcode);
  assign hazard  = HAZ_EN & ld_pend_p1 & i_valid & (ld_dst_p1 != '0)
                 & ((ld_dst_p1 == i_rs) | ((ld_dst_p1 == i_rt) & rt_used));
  assign o_ready = load_en & (state == RUN) & !hazard & !i_flush;
  assign xfer    = i_valid & o_ready;
  assign o_stall = (state == STALL) | ((state == RUN) & hazard);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (i_flush) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RUN: begin
          if (hazard & load_en) begin
            state_nxt = STALL;
            cnt_nxt   = CNT_LOAD;
          end
        end
        STALL: begin
          if (cnt == '0) begin
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - 2'd1;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= '0;
      opcode_p1  <= '0;
      funct_p1   <= '0;
      rs_p1      <= '0;
      rt_p1      <= '0;
      dst_p1     <= '0;
      dst_wr_p1  <= 1'b0;
      ld_pend_p1 <= 1'b0;
      ld_dst_p1  <= '0;
    end else if (i_flush) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= '0;
      dst_wr_p1  <= 1'b0;
      ld_pend_p1 <= 1'b0;
      ld_dst_p1  <= '0;
    end else if (load_en) begin
      if (xfer) begin
        vld_p1     <= 1'b1;
        ctrl_p1    <= ctrl_p0;
        opcode_p1  <= i_opcode;
        funct_p1   <= i_funct;
        rs_p1      <= i_rs;
        rt_p1      <= i_rt;
        dst_p1     <= dst_p0;
        dst_wr_p1  <= dst_wr_p0;
        ld_pend_p1 <= ctrl_p0[C_MEM_RD];
        ld_dst_p1  <= dst_p0;
      end else begin
        // Bubble: the slot is empty, and it breaks any load-use dependency
        vld_p1     <= 1'b0;
        ctrl_p1    <= '0;
        dst_wr_p1  <= 1'b0;
        ld_pend_p1 <= 1'b0;
        ld_dst_p1  <= '0;
      end
    end
  end

  assign o_valid  = vld_p1;
  assign o_ctrl   = ctrl_p1;
  assign o_opcode = opcode_p1;
  assign o_funct  = funct_p1;
  assign o_rs     = rs_p1;
  assign o_rt     = rt_p1;
  assign o_dst    = dst_p1;
  assign o_dst_wr = dst_wr_p1;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Testbench for id_ctrl_stage. Three instances share one stimulus stream:
// instance 0 uses defaults, instance 1 uses STALL_CYC=3, instance 2 has the
// interlock removed. A behavioural model per instance is compared against
// every DUT output on each falling edge, and directed literal expectations
// pin the model.
module tb_id_ctrl_stage;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    op, fn;
  logic [AW-1:0] rs, rt, rd;
  logic          vld, rdy, fl;

  logic [2:0]         d_ready, d_valid, d_dwr, d_stall;
  logic [2:0][14:0]   d_ctrl;
  logic [2:0][5:0]    d_op, d_fn;
  logic [2:0][AW-1:0] d_rs, d_rt, d_dst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    id_ctrl_stage #(
      .REG_AW   (AW),
      .HAZ_EN   ((g == 2) ? 1'b0 : 1'b1),
      .STALL_CYC((g == 1) ? 3 : 1)
    ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_opcode(op),
      .i_funct (fn),
      .i_rs    (rs),
      .i_rt    (rt),
      .i_rd    (rd),
      .i_valid (vld),
      .o_ready (d_ready[g]),
      .o_valid (d_valid[g]),
      .i_ready (rdy),
      .i_flush (fl),
      .o_ctrl  (d_ctrl[g]),
      .o_opcode(d_op[g]),
      .o_funct (d_fn[g]),
      .o_rs    (d_rs[g]),
      .o_rt    (d_rt[g]),
      .o_dst   (d_dst[g]),
      .o_dst_wr(d_dwr[g]),
      .o_stall (d_stall[g])
    );
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[inst%0d]: got 0x%0h expected 0x%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int sc_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic bit hz_of(input int k);
    return (k != 2);
  endfunction

  function automatic logic [14:0] ref_ctrl(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      if (f == 0 || f == 2 || f == 3) return 15'h0023;
      if (f == 4 || f == 6 || f == 7) return 15'h0022;
      return 15'h0020;
    end
    if (o >= 8 && o <= 15) return (o >= 12 && o <= 14) ? 15'h4004 : 15'h400C;
    case (o)
      6'h20: return 15'h00DC;
      6'h21: return 15'h019C;
      6'h22: return 15'h029C;
      6'h24: return 15'h005C;
      6'h25: return 15'h011C;
      6'h28: return 15'h0C0C;
      6'h29: return 15'h140C;
      6'h2B: return 15'h240C;
      default: return 15'h0000;
    endcase
  endfunction

  function automatic logic [AW-1:0] ref_dst(input logic [5:0] o, input logic [AW-1:0] t, input logic [AW-1:0] d);
    if (o == 6'h00) return d;
    if ((o >= 8 && o <= 15) || o == 6'h20 || o == 6'h21 || o == 6'h22 || o == 6'h24 || o == 6'h25) return t;
    return '0;
  endfunction

  bit            m_valid [3];
  logic [14:0]   m_ctrl  [3];
  logic [5:0]    m_op    [3];
  logic [5:0]    m_fn    [3];
  logic [AW-1:0] m_rs    [3];
  logic [AW-1:0] m_rt    [3];
  logic [AW-1:0] m_dst   [3];
  logic [AW-1:0] m_pend  [3];
  bit            m_dwr   [3];
  int            m_block [3];

  logic [14:0]   c_e;
  logic [AW-1:0] dst_e;
  bit            dw_e, haz_e, take_e, rdy_e, stall_e, st_e;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        chk("rst_valid", k, d_valid[k], 0);
        chk("rst_ctrl", k, d_ctrl[k], 0);
        chk("rst_dst_wr", k, d_dwr[k], 0);
        m_valid[k] = 0; m_ctrl[k] = '0; m_dwr[k] = 0;
        m_pend[k] = '0; m_block[k] = 0;
      end else begin
        c_e   = ref_ctrl(op, fn);
        dst_e = ref_dst(op, rt, rd);
        if (dst_e == '0) c_e = c_e & ~15'h4020;
        dw_e    = (c_e[5] | c_e[14] | c_e[4]) && (dst_e != '0);
        st_e    = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
        haz_e   = hz_of(k) && vld && (m_pend[k] != '0) &&
                  ((m_pend[k] == rs) || ((m_pend[k] == rt) && (op == 6'h00 || st_e)));
        take_e  = !m_valid[k] || rdy;
        rdy_e   = take_e && (m_block[k] == 0) && !haz_e && !fl;
        stall_e = (m_block[k] != 0) || haz_e;

        chk("valid", k, d_valid[k], m_valid[k]);
        chk("ctrl", k, d_ctrl[k], m_ctrl[k]);
        chk("dst_wr", k, d_dwr[k], m_dwr[k]);
        chk("ready", k, d_ready[k], rdy_e);
        chk("stall", k, d_stall[k], stall_e);
        if (m_valid[k]) begin
          chk("opcode", k, d_op[k], m_op[k]);
          chk("funct", k, d_fn[k], m_fn[k]);
          chk("rs", k, d_rs[k], m_rs[k]);
          chk("rt", k, d_rt[k], m_rt[k]);
          chk("dst", k, d_dst[k], m_dst[k]);
        end

        if (fl) begin
          m_valid[k] = 0; m_ctrl[k] = '0; m_dwr[k] = 0;
          m_pend[k] = '0; m_block[k] = 0;
        end else begin
          if (m_block[k] > 0) m_block[k] = m_block[k] - 1;
          else if (haz_e && take_e) m_block[k] = sc_of(k);
          if (take_e) begin
            if (vld && rdy_e) begin
              m_valid[k] = 1; m_ctrl[k] = c_e; m_dwr[k] = dw_e;
              m_op[k] = op; m_fn[k] = fn; m_rs[k] = rs; m_rt[k] = rt; m_dst[k] = dst_e;
              m_pend[k] = c_e[4] ? dst_e : '0;
            end else begin
              m_valid[k] = 0; m_ctrl[k] = '0; m_dwr[k] = 0; m_pend[k] = '0;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input bit v, input logic [5:0] o, input logic [5:0] f,
                       input int s, input int t, input int d, input bit r, input bit fx);
    vld = v; op = o; fn = f; rs = AW'(s); rt = AW'(t); rd = AW'(d); rdy = r; fl = fx;
  endtask

  task automatic drive(input bit v, input logic [5:0] o, input logic [5:0] f,
                       input int s, input int t, input int d, input bit r, input bit fx);
    apply(v, o, f, s, t, d, r, fx);
    @(posedge clk);
    #1;
  endtask

  int first_j [3];

  initial begin
    rst_n = 1'b0;
    apply(0, 6'h00, 6'h00, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("lit_rst_valid", k, d_valid[k], 0);
      chk("lit_rst_ctrl", k, d_ctrl[k], 0);
      chk("lit_rst_dst", k, d_dst[k], 0);
    end
    rst_n = 1'b1;

    // Decode patterns
    drive(1, 6'h08, 6'h00, 1, 3, 0, 1, 0);            // ADDI rt=3
    chk("lit_addi_valid", 0, d_valid[0], 1);
    chk("lit_addi_ctrl", 0, d_ctrl[0], 15'h400C);
    chk("lit_addi_dst", 0, d_dst[0], 3);
    chk("lit_addi_dst_wr", 0, d_dwr[0], 1);
    drive(1, 6'h08, 6'h00, 1, 0, 0, 1, 0);            // ADDI rt=0
    chk("lit_addi0_ctrl", 0, d_ctrl[0], 15'h000C);
    chk("lit_addi0_dst_wr", 0, d_dwr[0], 0);
    drive(1, 6'h0C, 6'h00, 1, 4, 0, 1, 0);            // ANDI
    chk("lit_andi_ctrl", 0, d_ctrl[0], 15'h4004);
    drive(1, 6'h00, 6'h20, 1, 2, 7, 1, 0);            // ADD rd=7
    chk("lit_add_ctrl", 0, d_ctrl[0], 15'h0020);
    drive(1, 6'h00, 6'h00, 1, 2, 2, 1, 0);            // SLL
    chk("lit_sll_ctrl", 0, d_ctrl[0], 15'h0023);
    drive(1, 6'h00, 6'h06, 1, 2, 2, 1, 0);            // SRLV
    drive(1, 6'h23, 6'h00, 1, 2, 2, 1, 0);            // undecoded
    chk("lit_undec_ctrl", 0, d_ctrl[0], 15'h0000);
    drive(1, 6'h22, 6'h00, 1, 9, 0, 1, 0);            // LW rt=9
    chk("lit_lw_ctrl", 0, d_ctrl[0], 15'h029C);
    drive(1, 6'h21, 6'h00, 2, 10, 0, 1, 0);           // LH
    drive(1, 6'h24, 6'h00, 2, 11, 0, 1, 0);           // LBU
    drive(1, 6'h25, 6'h00, 2, 12, 0, 1, 0);           // LHU
    drive(1, 6'h28, 6'h00, 3, 13, 0, 1, 0);           // SB
    drive(1, 6'h2B, 6'h00, 3, 14, 0, 1, 0);           // SW
    drive(1, 6'h3F, 6'h00, 3, 14, 0, 1, 0);           // unused opcode
    drive(0, 6'h00, 6'h00, 0, 0, 0, 1, 0);

    // LB rt=5 followed by ADD rs=5 held for several cycles
    drive(1, 6'h20, 6'h00, 1, 5, 0, 1, 0);
    for (int k = 0; k < 3; k++) first_j[k] = -1;
    for (int j = 1; j <= 7; j++) begin
      drive(1, 6'h00, 6'h20, 5, 2, 9, 1, 0);
      for (int k = 0; k < 3; k++)
        if (first_j[k] < 0 && d_valid[k] && d_op[k] == 6'h00) first_j[k] = j;
    end
    chk("lit_add_issue", 0, first_j[0], 3);
    chk("lit_add_issue", 1, first_j[1], 5);
    chk("lit_add_issue", 2, first_j[2], 1);
    drive(0, 6'h00, 6'h00, 0, 0, 0, 1, 0);

    // Store reading the loaded register through rt
    drive(1, 6'h22, 6'h00, 1, 6, 0, 1, 0);
    repeat (6) drive(1, 6'h2B, 6'h00, 1, 6, 0, 1, 0);
    drive(0, 6'h00, 6'h00, 0, 0, 0, 1, 0);
    // Immediate op with rt equal to load dst: rt is not a source, no hazard
    drive(1, 6'h22, 6'h00, 1, 6, 0, 1, 0);
    drive(1, 6'h08, 6'h00, 1, 6, 0, 1, 0);
    chk("lit_imm_nohaz", 0, d_valid[0], 1);
    // Load into register 0 never creates a dependency
    drive(1, 6'h20, 6'h00, 1, 0, 0, 1, 0);
    drive(1, 6'h00, 6'h20, 0, 0, 3, 1, 0);
    chk("lit_r0_nohaz", 0, d_op[0], 0);
    drive(0, 6'h00, 6'h00, 0, 0, 0, 1, 0);
    drive(0, 6'h00, 6'h00, 0, 0, 0, 1, 0);

    // Downstream stall with SH held
    drive(1, 6'h29, 6'h00, 1, 2, 0, 1, 0);
    for (int j = 0; j < 4; j++) begin
      drive(1, 6'h29, 6'h00, 1, 2, 0, 0, 0);
      chk("lit_sh_ctrl", 0, d_ctrl[0], 15'h140C);
      chk("lit_sh_ready", 0, d_ready[0], 0);
    end
    // Flush while downstream is stalled
    drive(1, 6'h29, 6'h00, 1, 2, 0, 0, 1);
    drive(0, 6'h00, 6'h00, 0, 0, 0, 1, 0);

    // Flush during STALL
    drive(1, 6'h20, 6'h00, 1, 5, 0, 1, 0);
    drive(1, 6'h00, 6'h20, 5, 2, 9, 1, 0);
    drive(1, 6'h00, 6'h20, 5, 2, 9, 1, 1);
    apply(1, 6'h00, 6'h20, 5, 2, 9, 1, 0);
    #1;
    chk("lit_flush_valid", 1, d_valid[1], 0);
    chk("lit_flush_stall", 1, d_stall[1], 0);
    chk("lit_flush_ready", 1, d_ready[1], 1);
    @(posedge clk);
    #1;
    drive(0, 6'h00, 6'h00, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-stream
    drive(1, 6'h08, 6'h00, 1, 3, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("lit_arst_valid", k, d_valid[k], 0);
      chk("lit_arst_ctrl", k, d_ctrl[k], 0);
      chk("lit_arst_dst", k, d_dst[k], 0);
      chk("lit_arst_opcode", k, d_op[k], 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 6'h08, 6'h00, 1, 4, 0, 1, 0);
    chk("lit_post_rst_valid", 0, d_valid[0], 1);
    chk("lit_post_rst_dst", 0, d_dst[0], 4);
    drive(0, 6'h00, 6'h00, 0, 0, 0, 1, 0);
    drive(0, 6'h00, 6'h00, 0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
